count_sr_down: RTL

- Loadable, parameterised down-counter/timer. Each count bit is held in its own set/reset flip-flop cell, and each cell's S/R pair is derived from the next-count value.
- Counts toward zero from a loaded value. Pulses a terminal-count flag when it reaches zero. Can auto-reload for periodic ticks.
- Serves as the down-direction companion to the existing SR-based up-counter. Used as a timeout and tick generator in the flip-flop library designs.

---
 rtl/count_sr_pkg.sv | 17 +
 rtl/srff_cell.sv | 22 ++
 rtl/count_sr_down.sv | 114 +++++++++++
 3 files changed

// File: rtl/count_sr_pkg.sv
// Shared types and constants for the SR-cell counter family.
// State encoding, default width and terminal-value constants used by count_sr_down.
package count_sr_pkg;

  localparam int unsigned DEFAULT_WIDTH = 3;

  // Terminal-value templates; the counter slices the low WIDTH bits.
  localparam logic [31:0] TERM_ZERO = 32'h0000_0000;
  localparam logic [31:0] TERM_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/srff_cell.sv
// Single-bit set/reset flip-flop with synchronous active-high reset.
// Holds when set and reset are both low; set wins if both were ever high.
module srff_cell (
  input  logic clk,
  input  logic rst,
  input  logic s_i,
  input  logic r_i,
  output logic q_o
);

  logic q_q;

  // Bit storage: reset clears, set/reset drive the stored value, else hold.
  always_ff @(posedge clk) begin
    if (rst)      q_q <= 1'b0;
    else if (s_i) q_q <= 1'b1;
    else if (r_i) q_q <= 1'b0;
  end

  assign q_o = q_q;

endmodule

// File: rtl/count_sr_down.sv
// Loadable down-counter/timer built from per-bit SR cells.
// Optional up/down direction control is enabled by defining COUNT_SR_UPDN_EN.
//
// state | meaning
// IDLE  | no count in progress; en ignored
// RUN   | counting toward the terminal value on enabled cycles
// DONE  | terminal value reached; reloads if reload_mode, else waits for load
module count_sr_down
  import count_sr_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             reload_mode,
`ifdef COUNT_SR_UPDN_EN
  input  logic             up_dn,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TERM_DN = TERM_ZERO[WIDTH-1:0];
`ifdef COUNT_SR_UPDN_EN
  localparam logic [WIDTH-1:0] TERM_UP = TERM_ONES[WIDTH-1:0];
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] set_v, rst_v;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] step;

`ifdef COUNT_SR_UPDN_EN
  assign term = up_dn ? TERM_UP : TERM_DN;
  assign step = up_dn ? (count_q + ONE) : (count_q - ONE);
`else
  assign term = TERM_DN;
  assign step = count_q - ONE;
`endif

  // Next-state, next-count and terminal-pulse decode.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      state_d  = (load_val != term) ? RUN : IDLE;
    end else begin
      unique case (state_q)
        RUN: begin
          if (en) begin
            count_d = step;
            if (step == term) begin
              tc_d    = 1'b1;
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (reload_mode && (reload_q != term)) begin
            count_d = reload_q;
            state_d = RUN;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM, reload value and terminal pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // Set only bits that rise, reset only bits that fall; unchanged bits hold.
  always_comb begin
    set_v = count_d & ~count_q;
    rst_v = ~count_d & count_q;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    srff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .s_i (set_v[i]),
      .r_i (rst_v[i]),
      .q_o (count_q[i])
    );
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == RUN);

endmodule
